// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Each RUN cycle does one shift-add or restoring-divide step on operand magnitudes; FIN applies the sign fix.
module muldiv_unit #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [W-1:0] wdat,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

    state_t         state_q,    state_d;
    logic [CW-1:0]  count_q,    count_d;
    logic [2*W-1:0] acc_q,      acc_d;      // mul: {partial, multiplier}; div: {remainder, dividend->quotient}
    logic [W-1:0]   m_q,        m_d;        // multiplicand magnitude, or divisor magnitude
    logic           is_div_q,   is_div_d;
    logic           neg_res_q,  neg_res_d;
    logic           neg_rem_q,  neg_rem_d;
    logic           div_zero_q, div_zero_d;
    logic [W-1:0]   hi_q,       hi_d;
    logic [W-1:0]   lo_q,       lo_d;
    logic           busy_q,     busy_d;
    logic           done_q,     done_d;

    logic           signed_op;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     mul_sum, div_rem, div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    // Datapath arithmetic shared by the FSM below.
    always_comb begin
        signed_op = op[0];
        abs_a     = (signed_op && opa[W-1]) ? ~opa + W'(1) : opa;
        abs_b     = (signed_op && opb[W-1]) ? ~opb + W'(1) : opb;
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_rem   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_rem - {1'b0, m_q};
        prod_fix  = neg_res_q ? ~acc_q + (2*W)'(1) : acc_q;
        // With a zero divisor the remainder path already reproduces the raw dividend.
        quo_fix   = div_zero_q ? '1 : (neg_res_q ? ~acc_q[W-1:0] + W'(1) : acc_q[W-1:0]);
        rem_fix   = neg_rem_q ? ~acc_q[2*W-1:W] + W'(1) : acc_q[2*W-1:W];
    end

    always_comb begin
        // NOTE: every _d gets a default first so no branch leaves it unassigned and infers a latch.
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        m_d        = m_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (hi_wen) hi_d = wdat;
                if (lo_wen) lo_d = wdat;
                if (start) begin
                    state_d    = S_RUN;
                    count_d    = '0;
                    is_div_d   = op[1];
                    neg_res_d  = signed_op && (opa[W-1] ^ opb[W-1]);
                    neg_rem_d  = signed_op && opa[W-1];
                    div_zero_d = (opb == '0);
                    m_d        = op[1] ? abs_b : abs_a;
                    acc_d      = {{W{1'b0}}, (op[1] ? abs_a : abs_b)};
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                    else              acc_d = {div_rem[W-1:0],  acc_q[W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    state_d = S_FIN;
                    count_d = '0;
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge _d values together.
        if (RST) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            m_q        <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model pushes expected HI/LO per launched op
// onto a scoreboard, which is popped and compared whenever done pulses.
module tb_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa, opb, wdat;
    logic         hi_wen, lo_wen;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    muldiv_unit #(.W(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .hi_wen (hi_wen),
        .lo_wen (lo_wen),
        .wdat   (wdat),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        r;
        logic [63:0] p;
        longint      sa, sb, q, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = sa * sb;
            2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    p = {m[31:0], q[31:0]};
                end
            end
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding op.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("done_without_op", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
            end
        end
    end

    // Launch one op from IDLE, then time it from the accept edge to the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, input bit with_write);
        int   n;
        exp_t e;
        @(negedge CLK);
        while (busy || done) @(negedge CLK);
        e     = model(o, a, b);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        if (with_write) begin
            hi_wen = 1'b1;
            lo_wen = 1'b1;
            wdat   = 32'hA5A5_0F0F;
        end
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        start  = 1'b0;
        hi_wen = 1'b0;
        lo_wen = 1'b0;
        op     = 2'($urandom);
        opa    = $urandom;
        opb    = $urandom;
        check("busy_c1", busy, 1);
        if (with_write) begin
            check("write_with_start_hi", hi, 32'hA5A5_0F0F);
            check("write_with_start_lo", lo, 32'hA5A5_0F0F);
            cur_hi = 32'hA5A5_0F0F;
            cur_lo = 32'hA5A5_0F0F;
        end
        n = 0;
        while (done !== 1'b1 && n < W + 10) begin
            @(posedge CLK);
            #1;
            n++;
            if (disturb && n == 5) begin
                start  = 1'b1;
                op     = ~o;
                hi_wen = 1'b1;
                lo_wen = 1'b1;
                wdat   = 32'hDEAD_BEEF;
            end
            if (disturb && n == 6) begin
                start  = 1'b0;
                hi_wen = 1'b0;
                lo_wen = 1'b0;
            end
            if (disturb && n == 7) begin
                check("mthi_busy_ignored", hi, cur_hi);
                check("mtlo_busy_ignored", lo, cur_lo);
            end
            if (n == W) check("busy_fin", busy, 1);
        end
        // Accept edge ends c0; done is visible in c(W+2), i.e. W+1 edges later.
        check("done_latency", n, W + 1);
        check("busy_in_done", busy, 0);
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        RST    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        opa    = '0;
        opb    = '0;
        hi_wen = 1'b0;
        lo_wen = 1'b0;
        wdat   = '0;

        // Reset held for two cycles.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Reset in the middle of RUN aborts the op without writing a result.
        @(negedge CLK);
        start = 1'b1;
        op    = 2'b00;
        opa   = 32'hFFFF_FFFF;
        opb   = 32'hFFFF_FFFF;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        check("busy_run", busy, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST  = 1'b0;
        cnt0 = done_cnt;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        repeat (40) @(negedge CLK);
        check("rst_mid_no_done", done_cnt, cnt0);
        check("rst_mid_hi_after", hi, 0);
        check("rst_mid_lo_after", lo, 0);

        // IDLE writes: both in one cycle share wdat, then a lone mtlo.
        @(negedge CLK);
        hi_wen = 1'b1;
        lo_wen = 1'b1;
        wdat   = 32'h0000_1234;
        @(negedge CLK);
        hi_wen = 1'b0;
        lo_wen = 1'b0;
        check("mthi_mtlo_hi", hi, 32'h0000_1234);
        check("mthi_mtlo_lo", lo, 32'h0000_1234);
        lo_wen = 1'b1;
        wdat   = 32'h0000_5678;
        @(negedge CLK);
        lo_wen = 1'b0;
        check("mtlo_hi", hi, 32'h0000_1234);
        check("mtlo_lo", lo, 32'h0000_5678);
        cur_hi = 32'h0000_1234;
        cur_lo = 32'h0000_5678;

        // Directed corner cases; consecutive calls also launch in the DONE+1 cycle.
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFF1);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        do_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);
        check("divu_zero_hi", hi, 32'd100);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        check("div_neg_zero_lo", lo, 32'hFFFF_FFFF);
        check("div_neg_zero_hi", hi, 32'hFFFF_FFF9);

        // start plus mthi/mtlo during RUN are ignored; only one done pulse.
        @(negedge CLK);
        cnt0 = done_cnt;
        do_op(2'b01, 32'd12345, 32'hFFFF_FD5A, 1'b1, 1'b0);
        repeat (45) @(negedge CLK);
        check("single_done", done_cnt - cnt0, 1);
        check("no_queued_start", busy, 0);

        // start pulsed only during DONE is dropped.
        do_op(2'b10, 32'd1000, 32'd7, 1'b0, 1'b0);
        @(negedge CLK);
        check("done_cycle", done, 1);
        start = 1'b1;
        op    = 2'b00;
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        #1;
        check("start_in_done_ignored", busy, 0);

        // Write together with start: write lands at c1, result overwrites in FIN.
        do_op(2'b10, 32'd77, 32'd5, 1'b0, 1'b1);

        // Random mix.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) rb = '0;
            do_op(ro, ra, rb, 1'b0, 1'b0);
        end

        repeat (3) @(negedge CLK);
        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
